// File: rtl/mem_resp_pkg.sv
// Shared definitions for the shared-memory responder: funct3 codes, FSM states
// and byte-lane helpers.
package mem_resp_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte lanes touched by an access of the given size (funct3[1:0]) at addr[1:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            2'b00:   mask = 4'b0001 << addr_lo;
            2'b01:   mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // funct3 legality; stores have no unsigned variants.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/shared_mem_responder_if.sv
// Core load/store port bundle between an initiator (core/arbiter) and the responder.
interface shared_mem_responder_if;

    logic [31:0] mem_addr_in;
    logic [31:0] mem_write_data_in;
    logic [2:0]  mem_funct3_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] mem_read_data_out;
    logic        mem_ready_out;
    logic        mem_err_out;

    modport master (
        output mem_addr_in,
        output mem_write_data_in,
        output mem_funct3_in,
        output mem_read_in,
        output mem_write_in,
        input  mem_read_data_out,
        input  mem_ready_out,
        input  mem_err_out
    );

    modport slave (
        input  mem_addr_in,
        input  mem_write_data_in,
        input  mem_funct3_in,
        input  mem_read_in,
        input  mem_write_in,
        output mem_read_data_out,
        output mem_ready_out,
        output mem_err_out
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational RV32 sizing: lane enables, store-data placement, load extension and
// misalignment detection.
module lsu_align
    import mem_resp_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] read_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] store_data_o,
    output logic [31:0] load_data_o,
    output logic        align_err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store data is replicated across lanes so byte_en alone picks the placement.
    always_comb begin
        byte_en_o    = lane_mask(funct3_i[1:0], addr_lo_i);
        store_data_o = store_data_i;
        case (funct3_i[1:0])
            2'b00:   store_data_o = {4{store_data_i[7:0]}};
            2'b01:   store_data_o = {2{store_data_i[15:0]}};
            default: store_data_o = store_data_i;
        endcase
    end

    // Load extraction and sign/zero extension.
    always_comb begin
        byte_sel    = read_word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? read_word_i[31:16] : read_word_i[15:0];
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            F3_W:    load_data_o = read_word_i;
            default: load_data_o = '0;
        endcase
    end

    // Halfwords need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        align_err_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0])
                   || ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    end

endmodule

// File: rtl/shared_mem_responder.sv
// Slow shared-memory responder: one request at a time, LATENCY wait states, RV32
// byte/halfword/word sizing and error flagging.
module shared_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_mem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_f3;
    logic          cur_rd;
    logic          cur_wr;
    logic          range_err;
    logic          cur_err;
    logic          commit;
    logic          mem_we;
    logic [AW-1:0] widx;
    logic [31:0]   read_word;
    logic [3:0]    byte_en;
    logic [31:0]   st_data;
    logic [31:0]   ld_data;
    logic          align_err;

    // With LATENCY=0 the access happens on the capture edge, so IDLE uses the live bus.
    always_comb begin
        if (state_q == IDLE) begin
            cur_addr  = bus.mem_addr_in;
            cur_wdata = bus.mem_write_data_in;
            cur_f3    = bus.mem_funct3_in;
            cur_rd    = bus.mem_read_in;
            cur_wr    = bus.mem_write_in;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = f3_q;
            cur_rd    = rd_q;
            cur_wr    = wr_q;
        end
    end

    lsu_align u_lsu_align (
        .funct3_i     (cur_f3),
        .addr_lo_i    (cur_addr[1:0]),
        .store_data_i (cur_wdata),
        .read_word_i  (read_word),
        .byte_en_o    (byte_en),
        .store_data_o (st_data),
        .load_data_o  (ld_data),
        .align_err_o  (align_err)
    );

    // Error classification, array read and the commit strobe for the edge entering RESP.
    always_comb begin
        widx      = cur_addr[AW+1:2];
        range_err = {2'b00, cur_addr[31:2]} >= DEPTH_WORDS;
        read_word = '0;
        if (!range_err) begin
            read_word = mem_q[widx];
        end
        cur_err = (cur_rd && cur_wr) || !f3_legal(cur_f3, cur_wr) || align_err || range_err;
        commit  = ((state_q == IDLE) && (LATENCY == 0) && (cur_rd || cur_wr))
               || ((state_q == WAIT) && (cnt_q == '0));
        mem_we  = commit && cur_wr && !cur_err;
    end

    // Next-state logic; response data/err are only non-zero while in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cur_rd || cur_wr) begin
                    addr_d  = cur_addr;
                    wdata_d = cur_wdata;
                    f3_d    = cur_f3;
                    rd_d    = cur_rd;
                    wr_d    = cur_wr;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit) begin
            err_d   = cur_err;
            rdata_d = (cur_err || !cur_rd) ? 32'd0 : ld_data;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane store commit; reset drops a store that has not yet committed.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

    // Registered outputs.
    always_comb begin
        bus.mem_ready_out     = (state_q == RESP);
        bus.mem_err_out       = err_q;
        bus.mem_read_data_out = rdata_q;
    end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Self-checking bench: directed and random requests against a byte-level memory model.
module tb_shared_mem_responder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Instance 0: LATENCY=2, 1024 words. Instance 1: LATENCY=0, 16 words.
    shared_mem_responder_if if2 ();
    shared_mem_responder_if if0 ();

    shared_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    shared_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    logic [31:0] model [2][1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        if (s == 0) begin
            if2.mem_read_in = rd; if2.mem_write_in = wr; if2.mem_funct3_in = f3;
            if2.mem_addr_in = a;  if2.mem_write_data_in = d;
        end else begin
            if0.mem_read_in = rd; if0.mem_write_in = wr; if0.mem_funct3_in = f3;
            if0.mem_addr_in = a;  if0.mem_write_data_in = d;
        end
    endtask

    task automatic sample(input int s, output logic rdy, output logic err, output logic [31:0] dat);
        if (s == 0) begin
            rdy = if2.mem_ready_out; err = if2.mem_err_out; dat = if2.mem_read_data_out;
        end else begin
            rdy = if0.mem_ready_out; err = if0.mem_err_out; dat = if0.mem_read_data_out;
        end
    endtask

    // Reference behaviour from the access rules; updates the model on a legal store.
    task automatic model_apply(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               output logic e, output logic [31:0] rdat);
        int          size;
        int          depth;
        int          off;
        logic [31:0] w;
        logic [31:0] v;
        depth = (s == 0) ? 1024 : 16;
        e     = 1'b0;
        rdat  = 32'd0;
        size  = 1 << f3[1:0];
        off   = int'(addr % 4);
        if (rd && wr) e = 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) e = 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
        if (!e && (off % size) != 0) e = 1'b1;
        if (!e && (addr >> 2) >= 32'(depth)) e = 1'b1;
        if (!e) begin
            w = model[s][addr >> 2];
            if (rd) begin
                v = w >> (8 * off);
                if (size == 1) v = f3[2] ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
                else if (size == 2) v = f3[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
                rdat = v;
            end else begin
                for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = data[8*i +: 8];
                model[s][addr >> 2] = w;
            end
        end
    endtask

    // One complete request: latency, err, data (loads/errors), optional literal and
    // single-cycle ready.
    task automatic txn(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data, input string tag,
                       input bit use_want = 1'b0, input logic [31:0] want = 32'd0);
        logic        e;
        logic [31:0] rdat;
        logic        r_rdy;
        logic        r_err;
        logic [31:0] r_dat;
        int          n;
        model_apply(s, rd, wr, f3, addr, data, e, rdat);
        @(negedge clk);
        drive(s, rd, wr, f3, addr, data);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            sample(s, r_rdy, r_err, r_dat);
        end while (!r_rdy && n < 20);
        drive(s, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check($sformatf("%s/latency", tag), 32'(n), (s == 0) ? 32'd3 : 32'd1);
        check($sformatf("%s/err", tag), 32'(r_err), 32'(e));
        if (rd || e) check($sformatf("%s/data", tag), r_dat, rdat);
        if (use_want) check($sformatf("%s/literal", tag), r_dat, want);
        @(negedge clk);
        sample(s, r_rdy, r_err, r_dat);
        check($sformatf("%s/ready_pulse", tag), 32'(r_rdy), 32'd0);
    endtask

    initial begin : main
        logic        r_rdy;
        logic        r_err;
        logic [31:0] r_dat;
        logic        e;
        logic [31:0] rdat;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        rd;
        logic        wr;
        int          k;

        checks   = 0;
        failures = 0;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 1024; i++) model[s][i] = 32'd0;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s, r_rdy, r_err, r_dat);
            check($sformatf("reset%0d/ready", s), 32'(r_rdy), 32'd0);
            check($sformatf("reset%0d/err", s), 32'(r_err), 32'd0);
            check($sformatf("reset%0d/data", s), r_dat, 32'd0);
        end
        rst = 1'b0;

        // Known contents for the region the random phase uses.
        for (int i = 0; i < 32; i++) txn(0, 1'b0, 1'b1, 3'd2, 32'(4 * i), 32'd0, "init");

        txn(0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
        txn(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, "lw10", 1'b1, 32'hDEADBEEF);
        txn(0, 1'b0, 1'b1, 3'd0, 32'h11, 32'h000000A5, "sb11");
        txn(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, "lw10b", 1'b1, 32'hDEADA5EF);
        txn(0, 1'b1, 1'b0, 3'd0, 32'h11, 32'd0, "lb11", 1'b1, 32'hFFFFFFA5);
        txn(0, 1'b1, 1'b0, 3'd4, 32'h11, 32'd0, "lbu11", 1'b1, 32'h000000A5);
        txn(0, 1'b0, 1'b1, 3'd1, 32'h22, 32'h00008001, "sh22");
        txn(0, 1'b1, 1'b0, 3'd1, 32'h22, 32'd0, "lh22", 1'b1, 32'hFFFF8001);
        txn(0, 1'b1, 1'b0, 3'd5, 32'h22, 32'd0, "lhu22", 1'b1, 32'h00008001);
        txn(0, 1'b1, 1'b0, 3'd2, 32'h20, 32'd0, "lw20", 1'b1, 32'h80010000);

        txn(0, 1'b1, 1'b0, 3'd2, 32'h13, 32'd0, "err_lw13", 1'b1, 32'd0);
        txn(0, 1'b0, 1'b1, 3'd1, 32'h21, 32'h0000FFFF, "err_sh21");
        txn(0, 1'b1, 1'b0, 3'd2, 32'h1000, 32'd0, "err_range", 1'b1, 32'd0);
        txn(0, 1'b1, 1'b0, 3'd3, 32'h10, 32'd0, "err_f3", 1'b1, 32'd0);
        txn(0, 1'b1, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, "err_rw", 1'b1, 32'd0);
        txn(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, "rb10", 1'b1, 32'hDEADA5EF);
        txn(0, 1'b1, 1'b0, 3'd2, 32'h20, 32'd0, "rb20", 1'b1, 32'h80010000);

        // Reset during WAIT drops the store.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 3'd2, 32'h40, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0;
            sample(0, r_rdy, r_err, r_dat);
            check($sformatf("rst_mid/ready%0d", i), 32'(r_rdy), 32'd0);
        end
        txn(0, 1'b1, 1'b0, 3'd2, 32'h40, 32'd0, "rst_lw40", 1'b1, 32'h0);

        // LATENCY=0: preload, then loads with the request held continuously.
        for (int i = 0; i < 16; i++) txn(1, 1'b0, 1'b1, 3'd2, 32'(4 * i), $urandom, "l0_init");
        @(negedge clk);
        k = 0;
        drive(1, 1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            f3 = (i % 2 == 0) ? 3'd2 : 3'd4;
            a  = (f3 == 3'd2) ? 32'(4 * i) : 32'(4 * i + 3);
            if (i == 0) a = 32'h0;
            drive(1, 1'b1, 1'b0, f3, a, 32'd0);
            model_apply(1, 1'b1, 1'b0, f3, a, 32'd0, e, rdat);
            @(negedge clk);
            sample(1, r_rdy, r_err, r_dat);
            check($sformatf("b2b%0d/ready", i), 32'(r_rdy), 32'd1);
            check($sformatf("b2b%0d/data", i), r_dat, rdat);
            if (i == 7) drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            @(negedge clk);
            sample(1, r_rdy, r_err, r_dat);
            check($sformatf("b2b%0d/gap", i), 32'(r_rdy), 32'd0);
        end

        // Random traffic on the LATENCY=2 instance.
        for (int i = 0; i < 200; i++) begin
            k  = int'($urandom_range(0, 99));
            rd = (k < 45) || (k >= 90);
            wr = (k >= 45);
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = $urandom | 32'h1000;
            txn(0, rd, wr, f3, a, $urandom, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
